// File: rtl/gcd_resp_buffer.sv
// rtl/gcd_resp_buffer.sv - GCD result FIFO with slot reservation and valid/ready output.
// Optional GCD_RESP_STATS_EN adds saturating accepted-result and drop counters.
module gcd_resp_buffer #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue,
    output logic              can_issue,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
`ifdef GCD_RESP_STATS_EN
    ,
    output logic [31:0]       results_total,
    output logic [15:0]       drops_total
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] L_DEPTH = CNT_W'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_reserved;
    logic              r_overflow;
    logic [DATA_W-1:0] r_out_data;

    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [PTR_W-1:0]  w_rd_next;
    logic [CNT_W:0]    w_committed;

    assign out_valid   = (r_count != '0);
    assign w_pop       = out_valid & out_ready;
    assign w_push      = in_valid & ((r_count < L_DEPTH) | w_pop);
    assign w_drop      = in_valid & ~w_push;
    assign w_rd_next   = w_pop ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;
    assign w_committed = {1'b0, r_count} + {1'b0, r_reserved};

    assign can_issue = (w_committed < {1'b0, L_DEPTH});
    assign out_data  = r_out_data;
    assign count     = r_count;
    assign overflow  = r_overflow;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // The head register is loaded with what mem[rd_ptr] will hold after this
    // edge; when the incoming push lands on the new head slot, bypass it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_out_data <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            r_rd_ptr <= w_rd_next;
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_push && (r_wr_ptr == w_rd_next)) begin
                r_out_data <= in_data;
            end else begin
                r_out_data <= r_mem[w_rd_next];
            end
        end
    end

    // Reservations track results still in flight inside the GCD engine.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_reserved <= '0;
        end else if (issue && !in_valid) begin
            if (r_reserved < L_DEPTH) begin
                r_reserved <= r_reserved + CNT_W'(1);
            end
        end else if (in_valid && !issue) begin
            if (r_reserved != '0) begin
                r_reserved <= r_reserved - CNT_W'(1);
            end
        end
    end

`ifdef GCD_RESP_STATS_EN
    logic [31:0] r_results_total;
    logic [15:0] r_drops_total;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_results_total <= '0;
            r_drops_total   <= '0;
        end else begin
            if (w_push && (r_results_total != '1)) begin
                r_results_total <= r_results_total + 32'd1;
            end
            if (w_drop && (r_drops_total != '1)) begin
                r_drops_total <= r_drops_total + 16'd1;
            end
        end
    end

    assign results_total = r_results_total;
    assign drops_total   = r_drops_total;
`endif

endmodule

// File: tb/tb_gcd_resp_buffer.sv
// tb/tb_gcd_resp_buffer.sv - self-checking bench for gcd_resp_buffer with a queue-based reference model.
module tb_gcd_resp_buffer;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              issue;
    logic              can_issue;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic [CNT_W-1:0]  count;
    logic              overflow;
`ifdef GCD_RESP_STATS_EN
    logic [31:0]       results_total;
    logic [15:0]       drops_total;
`endif

    gcd_resp_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .reset(reset),
        .issue(issue),
        .can_issue(can_issue),
        .in_valid(in_valid),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
        .count(count),
        .overflow(overflow)
`ifdef GCD_RESP_STATS_EN
        ,
        .results_total(results_total),
        .drops_total(drops_total)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [DATA_W-1:0] m_q[$];
    int                m_res;
    bit                m_ovf;
    int                m_results;
    int                m_drops;

    function automatic bit m_can();
        return (m_q.size() + m_res) < DEPTH;
    endfunction

    function automatic void m_clear();
        m_q.delete();
        m_res     = 0;
        m_ovf     = 1'b0;
        m_results = 0;
        m_drops   = 0;
    endfunction

    // One clock cycle: drive inputs, advance the model at the edge, return at negedge.
    task automatic cyc(input bit i_is, input bit i_iv, input logic [DATA_W-1:0] i_d, input bit i_rdy);
        bit pop;
        bit push;
        issue     = i_is;
        in_valid  = i_iv;
        in_data   = i_d;
        out_ready = i_rdy;
        @(posedge clk);
        pop  = (m_q.size() > 0) && i_rdy;
        push = i_iv && ((m_q.size() < DEPTH) || pop);
        if (pop) void'(m_q.pop_front());
        if (push) begin
            m_q.push_back(i_d);
            m_results++;
        end else if (i_iv) begin
            m_ovf = 1'b1;
            m_drops++;
        end
        if (i_is && !i_iv && m_res < DEPTH) m_res++;
        else if (i_iv && !i_is && m_res > 0) m_res--;
        @(negedge clk);
        issue     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        m_clear();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; issue = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        m_clear();
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        n_cmp++; if (can_issue !== 1'b1) begin n_fail++; $display("FAIL reset_can_issue: got %b want 1", can_issue); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        @(negedge clk);
        reset = 1'b0;
        cyc(0, 0, '0, 1);
        cyc(0, 0, '0, 0);
        n_cmp++; if (out_valid !== 1'b0 || can_issue !== 1'b1) begin n_fail++; $display("FAIL idle_state: got valid=%b can=%b want 0/1", out_valid, can_issue); end
        cyc(0, 1, 16'h00A1, 0);
        cyc(0, 1, 16'h00A2, 0);
        cyc(0, 1, 16'h00A3, 0);
        n_cmp++; if (count !== 3'd3) begin n_fail++; $display("FAIL burst_count: got %0d want 3", count); end
        #2;
        reset = 1'b1;
        m_clear();
        #1;
        n_cmp++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_async: got count=%0d valid=%b want 0/0", count, out_valid); end
        @(posedge clk);
        #1;
        n_cmp++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_next: got count=%0d valid=%b want 0/0", count, out_valid); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single_flow();
        cyc(1, 0, '0, 1);
        for (int c = 1; c < 5; c++) begin
            n_cmp++; if (can_issue !== 1'b1) begin n_fail++; $display("FAIL single_can_issue c%0d: got %b want 1", c, can_issue); end
            cyc(0, 0, '0, 1);
        end
        cyc(0, 1, 16'h0006, 1);
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 16'h0006) begin n_fail++; $display("FAIL single_out: got valid=%b data=%h want 1/0006", out_valid, out_data); end
        cyc(0, 0, '0, 1);
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL single_drain_count: got %0d want 0", count); end
    endtask

    task automatic test_fill_backpressure();
        logic [DATA_W-1:0] vals [4] = '{16'd3, 16'd5, 16'd7, 16'd9};
        for (int i = 0; i < 4; i++) cyc(1, 0, '0, 0);
        n_cmp++; if (can_issue !== 1'b0) begin n_fail++; $display("FAIL fill_can_issue: got %b want 0", can_issue); end
        for (int i = 0; i < 4; i++) cyc(0, 1, vals[i], 0);
        n_cmp++; if (count !== 3'd4 || out_data !== 16'd3) begin n_fail++; $display("FAIL fill_full: got count=%0d data=%h want 4/0003", count, out_data); end
        cyc(0, 0, '0, 0);
        n_cmp++; if (out_data !== 16'd3 || out_valid !== 1'b1) begin n_fail++; $display("FAIL fill_hold: got data=%h valid=%b want 0003/1", out_data, out_valid); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (out_valid !== 1'b1 || out_data !== vals[i]) begin n_fail++; $display("FAIL fill_drain%0d: got valid=%b data=%h want 1/%h", i, out_valid, out_data, vals[i]); end
            cyc(0, 0, '0, 1);
        end
        n_cmp++; if (can_issue !== 1'b1 || count !== 3'd0) begin n_fail++; $display("FAIL fill_empty: got can=%b count=%0d want 1/0", can_issue, count); end
    endtask

    task automatic test_full_push_pop();
        logic [DATA_W-1:0] vals [4] = '{16'd5, 16'd7, 16'd9, 16'h000B};
        cyc(0, 1, 16'd3, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, vals[i], 0);
        cyc(0, 1, 16'h000B, 1);
        n_cmp++; if (count !== 3'd4 || overflow !== 1'b0) begin n_fail++; $display("FAIL pushpop_full: got count=%0d ovf=%b want 4/0", count, overflow); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (out_valid !== 1'b1 || out_data !== vals[i]) begin n_fail++; $display("FAIL pushpop_drain%0d: got valid=%b data=%h want 1/%h", i, out_valid, out_data, vals[i]); end
            cyc(0, 0, '0, 1);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 1; i <= 4; i++) cyc(0, 1, 16'(i), 0);
        cyc(0, 1, 16'h00FF, 0);
        n_cmp++; if (overflow !== 1'b1 || count !== 3'd4) begin n_fail++; $display("FAIL ovf_drop: got ovf=%b count=%0d want 1/4", overflow, count); end
`ifdef GCD_RESP_STATS_EN
        n_cmp++; if (results_total !== 32'd4 || drops_total !== 16'd1) begin n_fail++; $display("FAIL ovf_stats: got results=%0d drops=%0d want 4/1", results_total, drops_total); end
`endif
        for (int i = 1; i <= 4; i++) begin
            n_cmp++; if (out_data !== 16'(i)) begin n_fail++; $display("FAIL ovf_drain%0d: got %h want %h", i, out_data, 16'(i)); end
            cyc(0, 0, '0, 1);
        end
        n_cmp++; if (overflow !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_sticky: got ovf=%b valid=%b want 1/0", overflow, out_valid); end
    endtask

    task automatic test_wrap();
        logic [DATA_W-1:0] got[$];
        int k = 0;
        apply_reset();
        for (int c = 0; c < 100 && got.size() < 10; c++) begin
            bit iv  = (c % 2 == 0) && (k < 10);
            bit rdy = (c % 2 == 1);
            if (out_valid && rdy) got.push_back(out_data);
            cyc(0, iv, 16'(k + 1), rdy);
            if (iv) k++;
        end
        n_cmp++; if (got.size() != 10) begin n_fail++; $display("FAIL wrap_count: got %0d results want 10", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            n_cmp++; if (got[i] !== 16'(i + 1)) begin n_fail++; $display("FAIL wrap_order%0d: got %h want %h", i, got[i], 16'(i + 1)); end
        end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL wrap_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            bit is  = m_can() ? ($urandom % 3 == 0) : ($urandom % 16 == 0);
            bit iv  = ($urandom % 2 == 0);
            bit rdy = ((c / 50) % 2 == 1) ? ($urandom % 4 == 0) : ($urandom % 4 != 0);
            logic [DATA_W-1:0] d = 16'($urandom);
            n_cmp++; if (out_valid !== (m_q.size() != 0)) begin n_fail++; $display("FAIL rnd_valid c%0d: got %b want %b", c, out_valid, m_q.size() != 0); end
            n_cmp++; if (count !== 3'(m_q.size())) begin n_fail++; $display("FAIL rnd_count c%0d: got %0d want %0d", c, count, m_q.size()); end
            n_cmp++; if (can_issue !== m_can()) begin n_fail++; $display("FAIL rnd_can_issue c%0d: got %b want %b", c, can_issue, m_can()); end
            n_cmp++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_overflow c%0d: got %b want %b", c, overflow, m_ovf); end
            if (m_q.size() != 0) begin
                n_cmp++; if (out_data !== m_q[0]) begin n_fail++; $display("FAIL rnd_data c%0d: got %h want %h", c, out_data, m_q[0]); end
            end
            cyc(is, iv, d, rdy);
        end
`ifdef GCD_RESP_STATS_EN
        n_cmp++; if (results_total !== 32'(m_results) || drops_total !== 16'(m_drops)) begin n_fail++; $display("FAIL rnd_stats: got %0d/%0d want %0d/%0d", results_total, drops_total, m_results, m_drops); end
`endif
    endtask

    initial begin
        test_reset();
        test_single_flow();
        test_fill_backpressure();
        test_full_push_pop();
        test_overflow();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
